inst_fetch_buffer: RTL and testbench

INST_FETCH_BUFFER -- requirements
Module: inst_fetch_buffer

---
 rtl/inst_fetch_buffer.sv | 186 ++++++++++++++++++
 tb/tb_inst_fetch_buffer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_buffer.sv
// -----------------------------------------------------------------------------
// inst_fetch_buffer
//
// Instruction fetch front end for a dual-issue decoder. Fetches 64-bit
// instruction pairs from instruction memory, one request in flight at a time,
// and buffers them in a small FIFO whose head is presented to decode.
//
// Branch redirects flush the FIFO, retarget the fetch PC and drop any response
// still in flight. A redirect to the odd word of a pair pads the lower slot of
// the first refetched pair with a nop so the target lands in the upper slot.
//
// Parameters
//   FIFO_DEPTH  number of buffered instruction pairs (power of two, >= 2)
//   NOP_INST    even-pipe nop used to pad the lower slot after an odd redirect
//   RESET_PC    first fetch address after reset
//
// Ports
//   clock         single clock, all state updates on the rising edge
//   reset         asynchronous active-low reset
//   imem_req      one-cycle pulse requesting a 64-bit pair
//   imem_addr     8-byte aligned pair address, valid while imem_req = 1
//   imem_rvalid   response strobe, responses return in request order
//   imem_rdata    fetched pair; [63:32] is the lower-address instruction
//                 (bits 0..31 in big-endian bit numbering)
//   stall         decode hold; the head pair is not consumed while high
//   branch_taken  redirect strobe from branch resolution
//   pc_input      redirect target byte address, word aligned
//   first_inst    head pair, lower-address slot (0 when empty)
//   second_inst   head pair, upper-address slot (0 when empty)
//   pc_output     byte address of first_inst (0 when empty)
//   inst_valid    head pair valid for decode
// -----------------------------------------------------------------------------
module inst_fetch_buffer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INST   = 32'h4020_0000,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [63:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] pc_input,
  output logic [31:0] first_inst,
  output logic [31:0] second_inst,
  output logic [31:0] pc_output,
  output logic        inst_valid
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] first;
    logic [31:0] second;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   head_ptr;
  logic [PTR_W-1:0]   tail_ptr;
  logic [CNT_W-1:0]   count;
  logic [31:0]        fetch_pc;     // address of the next pair to request
  logic [31:0]        req_pc;       // address of the pair currently in flight
  logic               outstanding;  // one request issued, response not yet seen
  logic               discard;      // in-flight response belongs to a flushed stream
  logic               pad_pending;  // next accepted pair follows an odd-word redirect

  // ---------------------------------------------------------------------------
  // Datapath control
  // ---------------------------------------------------------------------------
  logic             resp_accept;
  logic             push;
  logic             pop;
  logic             slot_free;
  logic [CNT_W-1:0] count_after;
  entry_t           push_entry;
  entry_t           head_entry;

  // A response only counts if we are waiting for one; stray strobes (for
  // example from a request issued before reset) fall through here.
  assign resp_accept = imem_rvalid & outstanding;

  // Redirect has priority: nothing enters or leaves the FIFO in that cycle.
  assign push = resp_accept & ~discard & ~branch_taken;
  assign pop  = inst_valid & ~stall & ~branch_taken;

  // The returning response frees the single request slot in the same cycle,
  // which lets a 1-cycle memory sustain one pair per clock.
  assign slot_free = ~outstanding | resp_accept;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    count_after = count;
    push_entry  = '0;

    count_after = count + CNT_W'(push) - CNT_W'(pop);

    push_entry.pc     = req_pc;
    push_entry.first  = pad_pending ? NOP_INST : imem_rdata[63:32];
    push_entry.second = imem_rdata[31:0];
  end

  // Request only when the FIFO will still have room after this cycle's push
  // and pop, so the response always has a slot waiting for it. Gating with
  // reset keeps the strobe quiet while reset is held.
  assign imem_req  = reset & ~branch_taken & slot_free & (count_after < DEPTH_CNT);
  assign imem_addr = imem_req ? fetch_pc : '0;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      head_ptr    <= '0;
      tail_ptr    <= '0;
      count       <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      pad_pending <= 1'b0;
    end else if (branch_taken) begin
      head_ptr    <= '0;
      tail_ptr    <= '0;
      count       <= '0;
      fetch_pc    <= pc_input & ~32'h7;
      pad_pending <= pc_input[2];
      // A response landing in the redirect cycle is simply not pushed. One
      // still in flight must be swallowed when it arrives, and the slot stays
      // busy until then so the redirected request cannot overtake it.
      outstanding <= outstanding & ~imem_rvalid;
      discard     <= outstanding & ~imem_rvalid;
    end else begin
      if (resp_accept) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end
      // A new request in the same cycle as a response re-arms the slot.
      if (imem_req) begin
        outstanding <= 1'b1;
        req_pc      <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd8;   // wraps 32'hFFFF_FFF8 -> 0
      end
      if (push) begin
        tail_ptr    <= tail_ptr + PTR_W'(1);
        pad_pending <= 1'b0;
      end
      if (pop) begin
        head_ptr <= head_ptr + PTR_W'(1);
      end
      count <= count_after;
    end
  end

  // ---------------------------------------------------------------------------
  // Pair storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; an entry is only observable once the
  // occupancy count covers it, and count is reset.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[tail_ptr] <= push_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode-facing outputs, driven straight from the head entry
  // ---------------------------------------------------------------------------
  assign head_entry  = fifo_mem[head_ptr];
  assign inst_valid  = (count != '0);
  assign first_inst  = inst_valid ? head_entry.first  : '0;
  assign second_inst = inst_valid ? head_entry.second : '0;
  assign pc_output   = inst_valid ? head_entry.pc     : '0;

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_buffer
//
// Directed bench for inst_fetch_buffer. A behavioural instruction memory with
// programmable latency answers requests in order. Whenever the bench starts a
// fetch stream (reset release or redirect) it loads the expected request
// addresses and expected decode pairs into scoreboard queues; a monitor pops
// and compares them as the design issues requests and decode consumes pairs.
// -----------------------------------------------------------------------------
module tb_inst_fetch_buffer;

  localparam logic [31:0] NOP = 32'h4020_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] first;
    logic [31:0] second;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [63:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] pc_input;
  logic [31:0] first_inst;
  logic [31:0] second_inst;
  logic [31:0] pc_output;
  logic        inst_valid;

  int cmp_cnt  = 0;
  int err_cnt  = 0;
  int req_seen = 0;
  int pop_seen = 0;
  int edge_cnt = 0;
  int mem_lat  = 1;

  logic [31:0] exp_a_q [$];
  ent_t        exp_e_q [$];
  pend_t       pend_q  [$];

  logic        neg_req;
  logic [31:0] neg_addr;

  inst_fetch_buffer dut (
    .clock        (clock),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .pc_input     (pc_input),
    .first_inst   (first_inst),
    .second_inst  (second_inst),
    .pc_output    (pc_output),
    .inst_valid   (inst_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory contents: every word is a distinct function of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Expected request addresses and decode pairs for a stream starting at
  // 'start' (pair aligned). 'pad' marks an odd-word redirect.
  task automatic load_stream(input logic [31:0] start, input logic pad);
    logic [31:0] a;
    ent_t        e;
    exp_a_q.delete();
    exp_e_q.delete();
    a = start;
    for (int i = 0; i < 64; i++) begin
      exp_a_q.push_back(a);
      e.pc     = a;
      e.first  = (pad && i == 0) ? NOP : mem_word(a);
      e.second = mem_word(a + 32'd4);
      exp_e_q.push_back(e);
      a = a + 32'd8;
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget && !inst_valid; i++) tick(1);
    check(tag, inst_valid, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Instruction memory: requests sampled mid-cycle, answered mem_lat cycles
  // later, strictly in order.
  // ---------------------------------------------------------------------------
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clock);
      neg_req  = imem_req;
      neg_addr = imem_addr;
      @(posedge clock);
      edge_cnt++;
      if (imem_rvalid && pend_q.size() > 0) void'(pend_q.pop_front());
      if (neg_req) pend_q.push_back('{neg_addr, edge_cnt + mem_lat - 1});
      #1;
      if (pend_q.size() > 0 && pend_q[0].due <= edge_cnt) begin
        imem_rvalid = 1'b1;
        imem_rdata  = {mem_word(pend_q[0].addr), mem_word(pend_q[0].addr + 32'd4)};
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard monitor: compares every request and every consumed pair.
  // ---------------------------------------------------------------------------
  initial begin
    ent_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (imem_req) begin
          req_seen++;
          check("req_queue_nonempty", 32'(exp_a_q.size() > 0), 1);
          if (exp_a_q.size() > 0) check("imem_addr", imem_addr, exp_a_q.pop_front());
        end
        if (inst_valid && !stall && !branch_taken) begin
          pop_seen++;
          check("pop_queue_nonempty", 32'(exp_e_q.size() > 0), 1);
          if (exp_e_q.size() > 0) begin
            e = exp_e_q.pop_front();
            check("pop_pc", pc_output, e.pc);
            check("pop_first", first_inst, e.first);
            check("pop_second", second_inst, e.second);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int pops_before;
    reset        = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    pc_input     = '0;
    mem_lat      = 1;
    tick(3);

    // Reset state
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_first", first_inst, 32'h0);
    check("rst_second", second_inst, 32'h0);
    check("rst_pc", pc_output, 32'h0);

    // Streaming with a 1-cycle memory: valid continuous once filled
    load_stream(32'h0, 1'b0);
    reset = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i >= 2) check("stream_valid", inst_valid, 1'b1);
    end

    // Long stall: FIFO fills to depth, requests stop, head held
    stall = 1'b1;
    tick(20);
    check("stall_req_low", imem_req, 1'b0);
    check("stall_valid", inst_valid, 1'b1);
    check("stall_head_pc", pc_output, exp_e_q[0].pc);
    check("stall_buffered", 32'(req_seen - pop_seen), 32'd4);
    stall = 1'b0;
    pops_before = pop_seen;
    for (int i = 0; i < 4; i++) begin
      check("release_valid", inst_valid, 1'b1);
      tick(1);
    end
    check("release_pops", 32'(pop_seen - pops_before), 32'd4);

    // Redirect while a 3-cycle request is in flight: stale response dropped
    mem_lat = 3;
    tick(6);
    for (int i = 0; i < 10 && !(pend_q.size() > 0 && !imem_rvalid); i++) tick(1);
    check("br_inflight_setup", 32'(pend_q.size() > 0 && !imem_rvalid), 1);
    branch_taken = 1'b1;
    pc_input     = 32'h0000_0100;
    load_stream(32'h0000_0100, 1'b0);
    #1;
    check("br_req_suppressed", imem_req, 1'b0);
    tick(1);
    branch_taken = 1'b0;
    check("br_flushed", inst_valid, 1'b0);
    wait_valid("br_refill", 20);
    check("br_head_pc", pc_output, 32'h0000_0100);
    check("br_head_first", first_inst, mem_word(32'h0000_0100));
    check("br_head_second", second_inst, mem_word(32'h0000_0104));

    // Odd-word redirect: lower slot padded with the nop
    mem_lat = 1;
    tick(8);
    branch_taken = 1'b1;
    pc_input     = 32'h0000_0104;
    load_stream(32'h0000_0100, 1'b1);
    tick(1);
    branch_taken = 1'b0;
    wait_valid("odd_refill", 20);
    check("odd_first_nop", first_inst, NOP);
    check("odd_second", second_inst, mem_word(32'h0000_0104));
    check("odd_pc", pc_output, 32'h0000_0100);
    tick(6);

    // Fetch PC wrap at the top of the address space
    branch_taken = 1'b1;
    pc_input     = 32'hFFFF_FFF8;
    load_stream(32'hFFFF_FFF8, 1'b0);
    tick(1);
    branch_taken = 1'b0;
    wait_valid("wrap_refill", 20);
    check("wrap_head_pc", pc_output, 32'hFFFF_FFF8);
    tick(6);
    check("wrap_next_pc", pc_output, exp_e_q[0].pc);

    // Reset mid-fill with 3 pairs buffered and one request in flight
    reset = 1'b0;
    tick(3);
    mem_lat = 3;
    stall   = 1'b1;
    load_stream(32'h0, 1'b0);
    reset = 1'b1;
    tick(10);
    check("mid_valid", inst_valid, 1'b1);
    check("mid_head_pc", pc_output, 32'h0);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", inst_valid, 1'b0);
    check("mid_rst_first", first_inst, 32'h0);
    check("mid_rst_second", second_inst, 32'h0);
    check("mid_rst_pc", pc_output, 32'h0);
    check("mid_rst_req", imem_req, 1'b0);
    check("mid_rst_addr", imem_addr, 32'h0);
    // Release in the cycle the pre-reset response comes back
    tick(1);
    #0;
    tick(1);
    load_stream(32'h0, 1'b0);
    stall = 1'b0;
    reset = 1'b1;
    wait_valid("restart_refill", 30);
    check("restart_pc", pc_output, 32'h0);
    check("restart_first", first_inst, mem_word(32'h0));
    check("restart_second", second_inst, mem_word(32'h4));
    tick(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
